uart_tx_cfg: RTL and testbench
==============================

Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter in the uart_loopback path.
- Data width is set at elaboration.
- Parity mode, stop-bit count and baud divisor are selectable at run time.
- A valid/ready handshake replaces the level-trigger start, and a one-cycle done pulse marks the end of each frame.
- Sits between a byte source (loopback receiver, FIFO, or PS register) and the board TXD pin.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
DIV_WIDTH, 16, width of the baud_div input.
DEFAULT_DIV, 433, documentation only: baud_div value for 115200 baud at 50 MHz (bit period = baud_div+1 = 434 clocks).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  byte to send; sent LSB first
tx_valid  input  1  source has a byte; held until accepted
tx_ready  output  1  block can accept a byte this cycle
parity_mode  input  2  00 none, 01 odd, 10 even, 11 none (reserved)
stop_bits  input  1  0 = one stop bit, 1 = two stop bits
baud_div  input  DIV_WIDTH  bit period minus one, in clk cycles
tx_busy  output  1  a frame is in progress
tx_done  output  1  one-cycle pulse at end of frame
serial_txd  output  1  serial line, idles high

Behaviour:
- Reset values (rst_n low, asynchronous): serial_txd=1, tx_ready=1, tx_busy=0, tx_done=0, state=IDLE, all counters 0.
- Accept: occurs on a rising edge where tx_valid & tx_ready are both high. At that edge the block latches tx_data, parity_mode, stop_bits and baud_div. Input changes after accept have no effect on the current frame.
- State machine: IDLE -> START -> DATA -> PARITY (skipped if mode none) -> STOP -> IDLE or START.
- Bit period P = latched baud_div + 1 cycles. baud_div=0 is legal and gives P=1. Every bit is held exactly P cycles.
- Registered outputs:
  - serial_txd goes 0 (start bit) in the cycle after accept.
  - tx_ready falls and tx_busy rises in that same cycle.
- Bit order: start(0), data[0]..data[DATA_BITS-1], parity, then stop(1) repeated 1 or 2 times.
- Parity is computed on the latched data:
  - even: parity bit = XOR of the data bits.
  - odd: parity bit = inverted XOR of the data bits.
- Frame length N = 1 + DATA_BITS + (parity ? 1 : 0) + (stop_bits ? 2 : 1) bits.
- Relative to accept edge = cycle 0, the frame occupies cycles 1..N*P.
- Final cycle of the last stop bit (cycle N*P): tx_done=1 and tx_ready=1, still with tx_busy=1.
- Back-to-back frames:
  - If tx_valid is high in cycle N*P, the new byte is accepted.
  - Its start bit begins in cycle N*P+1, so there is zero idle gap.
  - tx_done stays a single-cycle pulse for each frame.
- No new accept: state returns to IDLE, tx_busy=0, serial_txd stays 1.
- The bit-period counter counts 0..P-1. The bit index and stop counter advance only on terminal count. Neither counter ever exceeds its range.
- While busy, tx_valid is ignored except in the final cycle (tx_ready=1).
- Reset mid-frame: the line returns to 1 immediately (asynchronously). No tx_done is issued. The block is ready for a new accept after rst_n deasserts.
- parity_mode 11 behaves exactly as 00.

Test Plan:
1. DATA_BITS=8, baud_div=3 (P=4), no parity, 1 stop, tx_data=8'hA5 -> serial_txd holds each bit 4 cycles: 0,1,0,1,0,0,1,0,1,1. tx_done pulses once at cycle 40, and the line is idle-high from cycle 41.
2. tx_data=8'h07, even parity, 2 stops, baud_div=1 (P=2) -> bits 0,1,1,1,0,0,0,0,0,1(parity),1,1. tx_done at cycle 24. Repeat with odd parity -> parity bit 0.
3. tx_valid held high with 8'h55 then 8'hAA, 8N1, P=4 -> second start bit begins at cycle 41. Exactly two tx_done pulses (cycles 40 and 80), no idle cycles between frames.
4. Accept 8'hFF with P=4 and no parity, then at cycle 10 change tx_data=8'h00, baud_div=0 and parity_mode=10 -> frame is unchanged: 40 cycles, all data bits 1, no parity bit.
5. Assert rst_n=0 at cycle 15 of a frame -> serial_txd=1, tx_ready=1, tx_busy=0 immediately, no tx_done. After release, a fresh 8'h3C frame transmits correctly.
6. DATA_BITS=7, baud_div=0, odd parity, 1 stop, tx_data=7'h41 -> 10-cycle frame 0,1,0,0,0,0,0,1,1(parity),1, with tx_done at cycle 10.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter.
// Data width is fixed at elaboration. Parity mode, stop-bit count and baud
// divisor are sampled when a byte is accepted on the valid/ready handshake.
// Every output is a flop, fed from the next-state values.
module uart_tx_cfg #(
    parameter int DATA_BITS   = 8,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 433
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    input  logic [DIV_WIDTH-1:0] baud_div,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 serial_txd
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit for the given data: odd mode inverts the XOR reduction.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data,
                                        input logic [1:0]           mode);
        logic x;
        x = ^data;
        if (mode == 2'b01) begin
            parity_bit = ~x;
        end else begin
            parity_bit = x;
        end
    endfunction

    // Only the odd and even codes add a parity bit; 00 and 11 both mean none.
    function automatic logic parity_on(input logic [1:0] mode);
        parity_on = (mode == 2'b01) || (mode == 2'b10);
    endfunction

    // Frame state and counters
    state_t                 state_r;
    logic [DIV_WIDTH-1:0]   baud_cnt_r;
    logic [IDX_W-1:0]       bit_idx_r;
    logic                   stop_cnt_r;

    // Frame configuration captured at accept
    logic [DATA_BITS-1:0]   data_r;
    logic [1:0]             mode_r;
    logic                   stop2_r;
    logic [DIV_WIDTH-1:0]   div_r;

    // Next-state values
    state_t                 state_s;
    logic [DIV_WIDTH-1:0]   baud_cnt_s;
    logic [IDX_W-1:0]       bit_idx_s;
    logic                   stop_cnt_s;
    logic                   accept_s;
    logic                   tc_s;
    logic                   last_s;
    logic                   txd_s;
    logic                   ready_s;
    logic                   busy_s;

    // Next-state and counter logic; counters only advance on terminal count.
    always_comb begin
        accept_s   = tx_valid & tx_ready;
        tc_s       = (baud_cnt_r == div_r);
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_idx_s  = bit_idx_r;
        stop_cnt_s = stop_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s    = ST_START;
                    baud_cnt_s = {DIV_WIDTH{1'b0}};
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_START: begin
                if (tc_s) begin
                    state_s    = ST_DATA;
                    baud_cnt_s = {DIV_WIDTH{1'b0}};
                    bit_idx_s  = {IDX_W{1'b0}};
                end else begin
                    baud_cnt_s = baud_cnt_r + DIV_WIDTH'(1);
                end
            end
            ST_DATA: begin
                if (tc_s) begin
                    baud_cnt_s = {DIV_WIDTH{1'b0}};
                    if (bit_idx_r == LAST_IDX) begin
                        stop_cnt_s = 1'b0;
                        if (parity_on(mode_r)) begin
                            state_s = ST_PARITY;
                        end else begin
                            state_s = ST_STOP;
                        end
                    end else begin
                        bit_idx_s = bit_idx_r + IDX_W'(1);
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + DIV_WIDTH'(1);
                end
            end
            ST_PARITY: begin
                if (tc_s) begin
                    state_s    = ST_STOP;
                    baud_cnt_s = {DIV_WIDTH{1'b0}};
                    stop_cnt_s = 1'b0;
                end else begin
                    baud_cnt_s = baud_cnt_r + DIV_WIDTH'(1);
                end
            end
            ST_STOP: begin
                if (tc_s) begin
                    baud_cnt_s = {DIV_WIDTH{1'b0}};
                    if (stop_cnt_r == stop2_r) begin
                        // Final stop cycle: tx_ready is high, so a waiting
                        // byte starts the next frame with no idle gap.
                        stop_cnt_s = 1'b0;
                        if (accept_s) begin
                            state_s = ST_START;
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_s = 1'b1;
                    end
                end else begin
                    baud_cnt_s = baud_cnt_r + DIV_WIDTH'(1);
                end
            end
            default: begin
                state_s    = ST_IDLE;
                baud_cnt_s = {DIV_WIDTH{1'b0}};
                bit_idx_s  = {IDX_W{1'b0}};
                stop_cnt_s = 1'b0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    // A STOP state is never entered on an accept edge, so the captured
    // configuration is valid wherever it is used here.
    always_comb begin
        last_s = (state_s == ST_STOP) && (baud_cnt_s == div_r) &&
                 (stop_cnt_s == stop2_r);
        busy_s  = (state_s != ST_IDLE);
        ready_s = (state_s == ST_IDLE) || last_s;
        case (state_s)
            ST_IDLE:   txd_s = 1'b1;
            ST_START:  txd_s = 1'b0;
            ST_DATA:   txd_s = data_r[bit_idx_s];
            ST_PARITY: txd_s = parity_bit(data_r, mode_r);
            ST_STOP:   txd_s = 1'b1;
            default:   txd_s = 1'b1;
        endcase
    end

    // State, counter and registered-output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= {DIV_WIDTH{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            stop_cnt_r <= 1'b0;
            serial_txd <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_idx_r  <= bit_idx_s;
            stop_cnt_r <= stop_cnt_s;
            serial_txd <= txd_s;
            tx_ready   <= ready_s;
            tx_busy    <= busy_s;
            tx_done    <= last_s;
        end
    end

    // Capture data and line configuration on accept; held for the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= {DATA_BITS{1'b0}};
            mode_r  <= 2'b00;
            stop2_r <= 1'b0;
            div_r   <= DIV_WIDTH'(DEFAULT_DIV);
        end else if (accept_s) begin
            data_r  <= tx_data;
            mode_r  <= parity_mode;
            stop2_r <= stop_bits;
            div_r   <= baud_div;
        end else begin
            data_r  <= data_r;
            mode_r  <= mode_r;
            stop2_r <= stop2_r;
            div_r   <= div_r;
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: an 8-bit and a 7-bit instance. A queue model expands
// each accepted byte into its per-cycle line values; one compare process
// checks both instances on every falling edge, and directed tests add
// hand-computed timing and bit-pattern expectations.
module tb_uart_tx_cfg;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  d8_data;
    logic        d8_valid, d8_sb;
    logic [1:0]  d8_pm;
    logic [15:0] d8_div;
    logic        d8_ready, d8_busy, d8_done, d8_txd;

    logic [6:0]  d7_data;
    logic        d7_valid, d7_sb;
    logic [1:0]  d7_pm;
    logic [15:0] d7_div;
    logic        d7_ready, d7_busy, d7_done, d7_txd;

    uart_tx_cfg #(.DATA_BITS(8), .DIV_WIDTH(16), .DEFAULT_DIV(433)) dut8 (
        .clk(clk), .rst_n(rst_n), .tx_data(d8_data), .tx_valid(d8_valid),
        .tx_ready(d8_ready), .parity_mode(d8_pm), .stop_bits(d8_sb),
        .baud_div(d8_div), .tx_busy(d8_busy), .tx_done(d8_done),
        .serial_txd(d8_txd)
    );

    uart_tx_cfg #(.DATA_BITS(7), .DIV_WIDTH(16), .DEFAULT_DIV(433)) dut7 (
        .clk(clk), .rst_n(rst_n), .tx_data(d7_data), .tx_valid(d7_valid),
        .tx_ready(d7_ready), .parity_mode(d7_pm), .stop_bits(d7_sb),
        .baud_div(d7_div), .tx_busy(d7_busy), .tx_done(d7_done),
        .serial_txd(d7_txd)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Expected per-cycle entries {txd, done}; empty queue means idle line.
    logic [1:0] q8[$];
    logic [1:0] q7[$];
    int acc8[$], acc7[$], done8[$], done7[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Transmitted bit sequence of one frame, bit 0 of v sent first.
    task automatic frame_bits(input logic [8:0] d, input int nb, input logic [1:0] pm,
                              input logic sb, output logic [15:0] v, output int len);
        logic x;
        v = 16'h0000;
        x = 1'b0;
        len = 0;
        v[len] = 1'b0; len++;
        for (int i = 0; i < nb; i++) begin
            v[len] = d[i];
            x = x ^ d[i];
            len++;
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            v[len] = (pm == 2'b10) ? x : ~x;
            len++;
        end
        v[len] = 1'b1; len++;
        if (sb) begin
            v[len] = 1'b1; len++;
        end
    endtask

    // Model: accept when valid and the model says ready, then expand frame.
    logic [15:0] mv;
    int          ml, mp;
    bit          a8, a7;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q8.delete();
            q7.delete();
        end else begin
            a8 = d8_valid && (q8.size() <= 1);
            a7 = d7_valid && (q7.size() <= 1);
            if (q8.size() > 0) void'(q8.pop_front());
            if (q7.size() > 0) void'(q7.pop_front());
            if (a8) begin
                frame_bits({1'b0, d8_data}, 8, d8_pm, d8_sb, mv, ml);
                mp = int'(d8_div) + 1;
                for (int j = 0; j < ml; j++)
                    for (int k = 0; k < mp; k++)
                        q8.push_back({mv[j], (j == ml - 1) && (k == mp - 1)});
                acc8.push_back(cyc);
            end
            if (a7) begin
                frame_bits({2'b00, d7_data}, 7, d7_pm, d7_sb, mv, ml);
                mp = int'(d7_div) + 1;
                for (int j = 0; j < ml; j++)
                    for (int k = 0; k < mp; k++)
                        q7.push_back({mv[j], (j == ml - 1) && (k == mp - 1)});
                acc7.push_back(cyc);
            end
            cyc++;
        end
    end

    // Compare both instances against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        if (q8.size() > 0) begin
            chk("txd8", d8_txd, q8[0][1]);
            chk("done8", d8_done, q8[0][0]);
        end else begin
            chk("txd8", d8_txd, 1);
            chk("done8", d8_done, 0);
        end
        chk("busy8", d8_busy, q8.size() > 0);
        chk("ready8", d8_ready, q8.size() <= 1);
        if (q7.size() > 0) begin
            chk("txd7", d7_txd, q7[0][1]);
            chk("done7", d7_done, q7[0][0]);
        end else begin
            chk("txd7", d7_txd, 1);
            chk("done7", d7_done, 0);
        end
        chk("busy7", d7_busy, q7.size() > 0);
        chk("ready7", d7_ready, q7.size() <= 1);
        if (d8_done) done8.push_back(cyc);
        if (d7_done) done7.push_back(cyc);
    end

    function automatic int acc_n(input bit s7);
        return s7 ? acc7.size() : acc8.size();
    endfunction

    function automatic int q_n(input bit s7);
        return s7 ? q7.size() : q8.size();
    endfunction

    task automatic wait_acc(input bit s7, input int n0, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (acc_n(s7) > n0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout inst7=%0d actual=none required=accept", s7);
        end
    endtask

    task automatic wait_idle(input bit s7, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (q_n(s7) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL idle_timeout inst7=%0d actual=busy required=idle", s7);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic go8(input logic [7:0] d, input logic [1:0] pm, input logic sb,
                       input logic [15:0] div);
        int n0;
        n0 = acc8.size();
        d8_data = d; d8_pm = pm; d8_sb = sb; d8_div = div; d8_valid = 1'b1;
        wait_acc(1'b0, n0, 200);
        d8_valid = 1'b0;
    endtask

    logic [15:0] tv;
    int          tl, n0, d0;

    initial begin
        d8_data = 8'h00; d8_valid = 1'b0; d8_pm = 2'b00; d8_sb = 1'b0; d8_div = 16'd3;
        d7_data = 7'h00; d7_valid = 1'b0; d7_pm = 2'b00; d7_sb = 1'b0; d7_div = 16'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_txd", d8_txd, 1);
        chk("rst_ready", d8_ready, 1);
        chk("rst_busy", d8_busy, 0);
        chk("rst_done", d8_done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: A5, 8N1, P=4
        frame_bits(9'h0A5, 8, 2'b00, 1'b0, tv, tl);
        chk("pin_a5_bits", tv, 16'h034A);
        chk("pin_a5_len", tl, 10);
        d0 = done8.size();
        go8(8'hA5, 2'b00, 1'b0, 16'd3);
        wait_idle(1'b0, 200);
        chk("t1_ndone", done8.size() - d0, 1);
        chk("t1_done_cyc", done8[done8.size()-1] - acc8[acc8.size()-1], 40);

        // 2: 07, even then odd parity, 2 stops, P=2
        frame_bits(9'h007, 8, 2'b10, 1'b1, tv, tl);
        chk("pin_07e_bits", tv, 16'h0E0E);
        chk("pin_07e_len", tl, 12);
        go8(8'h07, 2'b10, 1'b1, 16'd1);
        wait_idle(1'b0, 200);
        chk("t2e_done_cyc", done8[done8.size()-1] - acc8[acc8.size()-1], 24);
        frame_bits(9'h007, 8, 2'b01, 1'b1, tv, tl);
        chk("pin_07o_bits", tv, 16'h0C0E);
        go8(8'h07, 2'b01, 1'b1, 16'd1);
        wait_idle(1'b0, 200);
        chk("t2o_done_cyc", done8[done8.size()-1] - acc8[acc8.size()-1], 24);

        // Reserved parity code behaves as none: 10 bits at P=3
        go8(8'h5A, 2'b11, 1'b0, 16'd2);
        wait_idle(1'b0, 200);
        chk("t2r_done_cyc", done8[done8.size()-1] - acc8[acc8.size()-1], 30);

        // 3: back-to-back 55 then AA with valid held high
        d0 = done8.size();
        n0 = acc8.size();
        d8_data = 8'h55; d8_pm = 2'b00; d8_sb = 1'b0; d8_div = 16'd3; d8_valid = 1'b1;
        wait_acc(1'b0, n0, 50);
        d8_data = 8'hAA;
        wait_acc(1'b0, n0 + 1, 100);
        d8_valid = 1'b0;
        wait_idle(1'b0, 200);
        chk("t3_ndone", done8.size() - d0, 2);
        chk("t3_acc_gap", acc8[n0+1] - acc8[n0], 40);
        chk("t3_done1", done8[d0] - acc8[n0], 40);
        chk("t3_done2", done8[d0+1] - acc8[n0], 80);

        // 4: input changes mid-frame do not affect the frame
        frame_bits(9'h0FF, 8, 2'b00, 1'b0, tv, tl);
        chk("pin_ff_bits", tv, 16'h03FE);
        n0 = acc8.size();
        go8(8'hFF, 2'b00, 1'b0, 16'd3);
        repeat (9) @(negedge clk);
        d8_data = 8'h00; d8_div = 16'd0; d8_pm = 2'b10;
        wait_idle(1'b0, 200);
        chk("t4_done_cyc", done8[done8.size()-1] - acc8[n0], 40);

        // 5: reset in cycle 15 (data bit 2 of 5A is 0), then a fresh 3C frame
        d0 = done8.size();
        go8(8'h5A, 2'b00, 1'b0, 16'd3);
        repeat (14) @(negedge clk);
        chk("t5_pre_txd", d8_txd, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_txd", d8_txd, 1);
        chk("t5_rst_ready", d8_ready, 1);
        chk("t5_rst_busy", d8_busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_no_done", done8.size() - d0, 0);
        n0 = acc8.size();
        go8(8'h3C, 2'b00, 1'b0, 16'd3);
        wait_idle(1'b0, 200);
        chk("t5_ndone", done8.size() - d0, 1);
        chk("t5_done_cyc", done8[done8.size()-1] - acc8[n0], 40);

        // 6: 7-bit instance, 41, odd parity, P=1
        frame_bits(9'h041, 7, 2'b01, 1'b0, tv, tl);
        chk("pin_41_bits", tv, 16'h0382);
        chk("pin_41_len", tl, 10);
        d0 = done7.size();
        n0 = acc7.size();
        d7_data = 7'h41; d7_pm = 2'b01; d7_sb = 1'b0; d7_div = 16'd0; d7_valid = 1'b1;
        wait_acc(1'b1, n0, 50);
        d7_valid = 1'b0;
        wait_idle(1'b1, 100);
        chk("t6_ndone", done7.size() - d0, 1);
        chk("t6_done_cyc", done7[done7.size()-1] - acc7[n0], 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
